// File: rtl/conv_window_buffer.sv
`timescale 1ns/1ps
// Sliding N x N window generator over a raster-order pixel stream. Keeps the last
// N-1 rows in line buffers and emits a packed window for every fully-covered pixel.
module conv_window_buffer #(
  parameter int N           = 3,
  parameter int BitSize     = 2,
  parameter int ImageWidth  = 28,
  parameter int ImageHeight = 28
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BitSize-1:0]      in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BitSize*N*N-1:0]  out_data,
  output logic                    frame_done
);

  localparam int CW      = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
  localparam int RW      = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;
  localparam int WinBits = BitSize * N * N;

  localparam logic [CW-1:0] CMax   = CW'(ImageWidth - 1);
  localparam logic [RW-1:0] RMax   = RW'(ImageHeight - 1);
  localparam logic [CW-1:0] CFirst = CW'(N - 1);
  localparam logic [RW-1:0] RFirst = RW'(N - 1);

  typedef logic [BitSize-1:0] pix_t;

  pix_t               line_q [N-1][ImageWidth];
  pix_t               line_d [N-1][ImageWidth];
  pix_t               win_q  [N][N];
  pix_t               win_d  [N][N];
  pix_t               col_pix [N];
  logic [CW-1:0]      c_q, c_d;
  logic [RW-1:0]      r_q, r_d;
  logic               out_valid_q, out_valid_d;
  logic [WinBits-1:0] out_data_q, out_data_d;
  logic [WinBits-1:0] win_packed;
  logic               frame_done_q, frame_done_d;
  logic               accept;
  logic               produce;

  assign in_ready   = !out_valid_q || out_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

  always_comb begin
    accept  = in_valid && in_ready;
    produce = accept && (r_q >= RFirst) && (c_q >= CFirst);

    c_d    = c_q;
    r_d    = r_q;
    line_d = line_q;
    win_d  = win_q;

    // Column c of the last N-1 rows plus the incoming pixel, oldest row first.
    for (int i = 0; i < N - 1; i++) begin
      col_pix[i] = line_q[i][c_q];
    end
    col_pix[N-1] = in_data;

    if (accept) begin
      if (c_q == CMax) begin
        c_d = '0;
        r_d = (r_q == RMax) ? '0 : r_q + RW'(1);
      end else begin
        c_d = c_q + CW'(1);
      end

      for (int i = 0; i < N - 2; i++) begin
        line_d[i][c_q] = line_q[i+1][c_q];
      end
      line_d[N-2][c_q] = in_data;

      for (int row = 0; row < N; row++) begin
        for (int col = 0; col < N - 1; col++) begin
          win_d[row][col] = win_q[row][col+1];
        end
        win_d[row][N-1] = col_pix[row];
      end
    end

    win_packed = '0;
    for (int row = 0; row < N; row++) begin
      for (int col = 0; col < N; col++) begin
        win_packed[BitSize*(row*N+col) +: BitSize] = win_d[row][col];
      end
    end

    // A new window replaces the held one; otherwise it stays until taken.
    out_valid_d  = produce || (out_valid_q && !out_ready);
    out_data_d   = produce ? win_packed : out_data_q;
    frame_done_d = accept && (c_q == CMax) && (r_q == RMax);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      c_q          <= '0;
      r_q          <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      c_q          <= c_d;
      r_q          <= r_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Stale contents after reset are harmless: no window is formed until N-1 fresh rows exist.
  always_ff @(posedge clk) begin
    line_q <= line_d;
    win_q  <= win_d;
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
`timescale 1ns/1ps
// Scoreboard bench for conv_window_buffer: a frame-array reference model queues the
// expected windows at accept time; a negedge monitor compares whatever the DUT presents.
module tb_conv_window_buffer;

  localparam int N       = 3;
  localparam int BitSize = 4;
  localparam int W       = 4;
  localparam int H       = 4;
  localparam int WinBits = BitSize * N * N;

  localparam logic [WinBits-1:0] FirstWin =
    {4'd10, 4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd2, 4'd1, 4'd0};
  localparam logic [WinBits-1:0] LastWin =
    {4'd15, 4'd14, 4'd13, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5};

  logic               clk = 1'b0;
  logic               res_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [BitSize-1:0] in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [WinBits-1:0] out_data;
  logic               frame_done;

  conv_window_buffer #(
    .N(N), .BitSize(BitSize), .ImageWidth(W), .ImageHeight(H)
  ) dut (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [WinBits-1:0] expQ[$];
  logic [WinBits-1:0] gotLog[$];
  logic [BitSize-1:0] frameImg [H][W];
  int  modelR = 0;
  int  modelC = 0;
  int  lastPixelEvents = 0;
  int  seenEvents = 0;
  bit  fdExpect = 0;
  int  windowsSeen = 0;
  int  frameDoneSeen = 0;
  int  readyMode = 0;
  bit  monitorOn = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: remember the whole frame and cut windows straight out of it.
  task automatic modelAccept(input logic [BitSize-1:0] pix);
    logic [WinBits-1:0] w;
    frameImg[modelR][modelC] = pix;
    if (modelR >= N - 1 && modelC >= N - 1) begin
      w = '0;
      for (int row = 0; row < N; row++)
        for (int col = 0; col < N; col++)
          w[BitSize*(row*N+col) +: BitSize] = frameImg[modelR-N+1+row][modelC-N+1+col];
      expQ.push_back(w);
    end
    if (modelR == H - 1 && modelC == W - 1) lastPixelEvents++;
    modelC++;
    if (modelC == W) begin
      modelC = 0;
      modelR = (modelR == H - 1) ? 0 : modelR + 1;
    end
  endtask

  task automatic modelReset();
    modelR = 0;
    modelC = 0;
    expQ.delete();
  endtask

  task automatic applyStimulus(input logic [BitSize-1:0] pix, input int maxGap);
    bit accepted;
    int gap;
    gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = pix;
    accepted = 0;
    for (int t = 0; t < 200 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready) begin
        modelAccept(pix);
        accepted = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("accept_timeout", 64'(accepted), 64'd1);
  endtask

  task automatic streamFrame(input bit rampValues, input int count, input int maxGap);
    for (int i = 0; i < count; i++) begin
      if (rampValues) applyStimulus(BitSize'(i % (W * H)), maxGap);
      else            applyStimulus(BitSize'($urandom_range(0, 15)), maxGap);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && (expQ.size() != 0 || out_valid); t++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic assertResetChecks(input string tag);
    #1;
    checkOutput({tag, "_out_valid"},  64'(out_valid), 64'd0);
    checkOutput({tag, "_out_data"},   64'(out_data), 64'd0);
    checkOutput({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    checkOutput({tag, "_in_ready"},   64'(in_ready), 64'd1);
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    res_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);
  endtask

  // Monitor: compare every presented window against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (res_n && monitorOn) begin
      checkOutput("frame_done", 64'(frame_done), 64'(fdExpect));
      if (frame_done) frameDoneSeen++;
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_window", 64'(out_valid), 64'd0);
        end else begin
          checkOutput("window", 64'(out_data), 64'(expQ[0]));
          if (out_ready) begin
            gotLog.push_back(out_data);
            void'(expQ.pop_front());
            windowsSeen++;
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    fdExpect   = (lastPixelEvents != seenEvents);
    seenEvents = lastPixelEvents;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int startWin;
    int startFd;

    $display("[TB] start");
    #2;
    assertResetChecks("reset");
    releaseReset();
    monitorOn = 1;

    // Basic windowing with ramp pixels.
    $display("[TB] basic windowing");
    gotLog.delete();
    startWin = windowsSeen;
    streamFrame(1, 16, 0);
    drain();
    checkOutput("basic_count", 64'(windowsSeen - startWin), 64'd4);
    if (gotLog.size() == 4) begin
      checkOutput("basic_first", 64'(gotLog[0]), 64'(FirstWin));
      checkOutput("basic_last",  64'(gotLog[3]), 64'(LastWin));
    end

    // Backpressure: downstream stalls from the start, so the first window is held.
    $display("[TB] backpressure");
    gotLog.delete();
    startWin = windowsSeen;
    readyMode = 1;
    fork
      streamFrame(1, 16, 0);
      begin
        bit seen;
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
          @(negedge clk);
          seen = out_valid;
        end
        checkOutput("bp_window_seen", 64'(seen), 64'd1);
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          checkOutput("bp_hold_data", 64'(out_data), 64'(FirstWin));
          checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        end
        readyMode = 0;
      end
    join
    drain();
    checkOutput("bp_count", 64'(windowsSeen - startWin), 64'd4);
    if (gotLog.size() == 4) begin
      checkOutput("bp_first", 64'(gotLog[0]), 64'(FirstWin));
      checkOutput("bp_last",  64'(gotLog[3]), 64'(LastWin));
    end

    // Two random frames back to back.
    $display("[TB] frame boundary");
    startWin = windowsSeen;
    startFd  = frameDoneSeen;
    streamFrame(0, 32, 0);
    drain();
    @(posedge clk);
    #1;
    checkOutput("fb_count", 64'(windowsSeen - startWin), 64'd8);
    checkOutput("fb_frame_done_count", 64'(frameDoneSeen - startFd), 64'd2);

    // Reset mid-frame after pixel 9.
    $display("[TB] reset mid-frame");
    streamFrame(1, 10, 0);
    res_n = 1'b0;
    modelReset();
    assertResetChecks("midreset");
    releaseReset();
    gotLog.delete();
    startWin = windowsSeen;
    streamFrame(1, 16, 0);
    drain();
    checkOutput("midreset_count", 64'(windowsSeen - startWin), 64'd4);
    if (gotLog.size() == 4) begin
      checkOutput("midreset_first", 64'(gotLog[0]), 64'(FirstWin));
      checkOutput("midreset_last",  64'(gotLog[3]), 64'(LastWin));
    end

    // Reset while a window is being held by backpressure.
    $display("[TB] reset with pending window");
    readyMode = 1;
    streamFrame(1, 11, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("pending_out_valid", 64'(out_valid), 64'd1);
    res_n = 1'b0;
    modelReset();
    readyMode = 0;
    assertResetChecks("pendreset");
    releaseReset();

    // Random idle gaps and random downstream readiness.
    $display("[TB] idle gaps");
    gotLog.delete();
    startWin = windowsSeen;
    readyMode = 2;
    streamFrame(1, 16, 3);
    readyMode = 0;
    drain();
    checkOutput("gaps_count", 64'(windowsSeen - startWin), 64'd4);
    if (gotLog.size() == 4) begin
      checkOutput("gaps_first", 64'(gotLog[0]), 64'(FirstWin));
      checkOutput("gaps_last",  64'(gotLog[3]), 64'(LastWin));
    end

    // Longer random run to stress handshakes across several frames.
    $display("[TB] random multi-frame");
    startWin = windowsSeen;
    readyMode = 2;
    streamFrame(0, 48, 2);
    readyMode = 0;
    drain();
    checkOutput("rand_count", 64'(windowsSeen - startWin), 64'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
